spi_clk_rst_sink: RTL



---
 rtl/spi_clk_rst_sink.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/spi_clk_rst_sink.sv
// SPI serial-clock generator with reset-release synchroniser.
// Produces bursts of nbits sclk cycles with lead/trail edge strobes and a done strobe.
module spi_clk_rst_sink #(
  parameter int DIV_W       = 8,
  parameter int CNT_W       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] nbits,
  input  logic             cpol,
  output logic             rst_sync_n,
  output logic             busy,
  output logic             sclk,
  output logic             lead_edge,
  output logic             trail_edge,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, LEAD, TRAIL} state_t;

  logic [SYNC_STAGES-1:0] sync_reg;

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] hcnt_reg, hcnt_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [CNT_W-1:0] bcnt_reg, bcnt_next;
  logic             cpol_reg, cpol_next;
  logic             busy_reg, busy_next;
  logic             sclk_reg, sclk_next;
  logic             lead_reg, lead_next;
  logic             trail_reg, trail_next;
  logic             done_reg, done_next;

  // Ones shift in after release; the last stage is the synchronised reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_n = sync_reg[SYNC_STAGES-1];

  always_comb begin
    state_next = state_reg;
    hcnt_next  = hcnt_reg;
    div_next   = div_reg;
    bcnt_next  = bcnt_reg;
    cpol_next  = cpol_reg;
    busy_next  = busy_reg;
    sclk_next  = sclk_reg;
    lead_next  = 1'b0;
    trail_next = 1'b0;
    done_next  = 1'b0;

    if (!rst_sync_n) begin
      state_next = IDLE;
      hcnt_next  = '0;
      div_next   = '0;
      bcnt_next  = '0;
      cpol_next  = 1'b0;
      busy_next  = 1'b0;
      sclk_next  = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          sclk_next = cpol;
          if (start) begin
            div_next   = div;
            cpol_next  = cpol;
            hcnt_next  = div;
            bcnt_next  = nbits;
            busy_next  = 1'b1;
            state_next = LEAD;
          end
        end
        LEAD: begin
          // bcnt can only be zero here for an empty burst: finish without toggling.
          if (bcnt_reg == '0) begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
          end else if (hcnt_reg == '0) begin
            sclk_next  = ~cpol_reg;
            lead_next  = 1'b1;
            hcnt_next  = div_reg;
            state_next = TRAIL;
          end else begin
            hcnt_next = hcnt_reg - DIV_W'(1);
          end
        end
        TRAIL: begin
          if (hcnt_reg == '0) begin
            sclk_next  = cpol_reg;
            trail_next = 1'b1;
            hcnt_next  = div_reg;
            bcnt_next  = bcnt_reg - CNT_W'(1);
            if (bcnt_reg == CNT_W'(1)) begin
              done_next  = 1'b1;
              busy_next  = 1'b0;
              state_next = IDLE;
            end else begin
              state_next = LEAD;
            end
          end else begin
            hcnt_next = hcnt_reg - DIV_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      hcnt_reg  <= '0;
      div_reg   <= '0;
      bcnt_reg  <= '0;
      cpol_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      sclk_reg  <= 1'b0;
      lead_reg  <= 1'b0;
      trail_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      hcnt_reg  <= hcnt_next;
      div_reg   <= div_next;
      bcnt_reg  <= bcnt_next;
      cpol_reg  <= cpol_next;
      busy_reg  <= busy_next;
      sclk_reg  <= sclk_next;
      lead_reg  <= lead_next;
      trail_reg <= trail_next;
      done_reg  <= done_next;
    end
  end

  assign busy       = busy_reg;
  assign sclk       = sclk_reg;
  assign lead_edge  = lead_reg;
  assign trail_edge = trail_reg;
  assign done       = done_reg;

endmodule
